// File: rtl/rv_pkg.sv
// Shared core constants and the writeback entry layout.
package rv_pkg;

    localparam int XLEN        = 32;
    localparam int REG_AW      = 5;
    localparam int WB_LD_DEPTH = 4;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO for the writeback stage; exposes every slot's rd and
// liveness so the stage can detect WAW hazards against queued loads.
module wb_fifo #(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int REG_AW = rv_pkg::REG_AW,
    parameter int DEPTH  = rv_pkg::WB_LD_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [REG_AW-1:0]         push_rd,
    input  logic [XLEN-1:0]           push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic [REG_AW-1:0]         head_rd,
    output logic [XLEN-1:0]           head_data,
    output logic [DEPTH*REG_AW-1:0]   entry_rd,
    output logic [DEPTH-1:0]          entry_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_rd   = mem[rd_ptr].rd;
    assign head_data = mem[rd_ptr].data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Payload storage is qualified by count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= '{rd: push_rd, data: push_data};
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        entry_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
            entry_rd[i*REG_AW +: REG_AW] = mem[i].rd;
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback stage: single write port shared by the ALU
// (priority) and an in-order queue of load results.
module rf_writeback #(
    parameter int XLEN     = rv_pkg::XLEN,
    parameter int REG_AW   = rv_pkg::REG_AW,
    parameter int LD_DEPTH = rv_pkg::WB_LD_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alu_valid,
    input  logic [REG_AW-1:0]           alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    output logic                        alu_ready,
    input  logic                        ld_valid,
    input  logic [REG_AW-1:0]           ld_rd,
    input  logic [XLEN-1:0]             ld_data,
    output logic                        ld_ready,
    output logic [REG_AW-1:0]           rf_a3,
    output logic [XLEN-1:0]             rf_write_data,
    output logic                        rf_write_enable,
    output logic [(1<<REG_AW)-1:0]      busy_mask,
    output logic [$clog2(LD_DEPTH):0]   ld_count
);

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic [REG_AW-1:0]          head_rd;
    logic [XLEN-1:0]            head_data;
    logic [LD_DEPTH*REG_AW-1:0] entry_rd;
    logic [LD_DEPTH-1:0]        entry_valid;
    logic                       waw_hit;
    logic                       alu_accept;

    wb_fifo #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .DEPTH  (LD_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (fifo_push),
        .push_rd     (ld_rd),
        .push_data   (ld_data),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (ld_count),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

    always_comb begin
        waw_hit = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (entry_valid[i] && (entry_rd[i*REG_AW +: REG_AW] == alu_rd))
                waw_hit = 1'b1;
        end
    end

    // Blocking the ALU when full guarantees the head drains every cycle.
    assign alu_ready  = !fifo_full && !((alu_rd != '0) && waw_hit);
    assign alu_accept = alu_valid && alu_ready;
    assign fifo_pop   = !fifo_empty && !alu_accept;
    assign ld_ready   = !fifo_full || fifo_pop;
    assign fifo_push  = ld_valid && ld_ready;

    // An x0 winner is consumed without disturbing the held index/data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_a3           <= '0;
            rf_write_data   <= '0;
            rf_write_enable <= 1'b0;
        end else if (alu_accept) begin
            rf_write_enable <= (alu_rd != '0);
            if (alu_rd != '0) begin
                rf_a3         <= alu_rd;
                rf_write_data <= alu_data;
            end
        end else if (fifo_pop) begin
            rf_write_enable <= (head_rd != '0);
            if (head_rd != '0) begin
                rf_a3         <= head_rd;
                rf_write_data <= head_data;
            end
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (entry_valid[i])
                busy_mask[entry_rd[i*REG_AW +: REG_AW]] = 1'b1;
        end
        if (rf_write_enable)
            busy_mask[rf_a3] = 1'b1;
        busy_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: a queue-based reference model predicts
// one write-port outcome per cycle; an independent monitor checks them.
module tb_rf_writeback;
    import rv_pkg::*;

    localparam int LD = WB_LD_DEPTH;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   alu_valid = 1'b0;
    logic [REG_AW-1:0]      alu_rd = '0;
    logic [XLEN-1:0]        alu_data = '0;
    logic                   alu_ready;
    logic                   ld_valid = 1'b0;
    logic [REG_AW-1:0]      ld_rd = '0;
    logic [XLEN-1:0]        ld_data = '0;
    logic                   ld_ready;
    logic [REG_AW-1:0]      rf_a3;
    logic [XLEN-1:0]        rf_write_data;
    logic                   rf_write_enable;
    logic [(1<<REG_AW)-1:0] busy_mask;
    logic [$clog2(LD):0]    ld_count;

    rf_writeback dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .ld_valid        (ld_valid),
        .ld_rd           (ld_rd),
        .ld_data         (ld_data),
        .ld_ready        (ld_ready),
        .rf_a3           (rf_a3),
        .rf_write_data   (rf_write_data),
        .rf_write_enable (rf_write_enable),
        .busy_mask       (busy_mask),
        .ld_count        (ld_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wr_t;

    wr_t               exp_q[$];
    wb_entry_t         ld_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    bit                out_we = 1'b0;
    logic [REG_AW-1:0] out_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check combinational outputs against the model, advance the model.
    task automatic step(input bit av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] adat,
                        input bit lv, input logic [REG_AW-1:0] lrd, input logic [XLEN-1:0] ldat);
        bit                     full, hit, e_ar, e_lr, win_alu, win_ld;
        logic [(1<<REG_AW)-1:0] mask;
        wr_t                    w;
        wb_entry_t              e;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid = lv;  ld_rd = lrd;  ld_data = ldat;
        #1;
        full = (ld_q.size() == LD);
        hit = 1'b0;
        foreach (ld_q[i]) if (ld_q[i].rd == ard) hit = 1'b1;
        e_ar    = !full && !((ard != 0) && hit);
        win_alu = av && e_ar;
        win_ld  = !win_alu && (ld_q.size() > 0);
        e_lr    = !full || win_ld;
        mask = '0;
        foreach (ld_q[i]) mask[ld_q[i].rd] = 1'b1;
        if (out_we) mask[out_rd] = 1'b1;
        mask[0] = 1'b0;
        chk("alu_ready", 64'(alu_ready), 64'(e_ar));
        chk("ld_ready", 64'(ld_ready), 64'(e_lr));
        chk("ld_count", 64'(ld_count), 64'(ld_q.size()));
        chk("busy_mask", 64'(busy_mask), 64'(mask));
        w.we = 1'b0; w.rd = '0; w.data = '0;
        if (win_alu) begin
            w.we = (ard != 0); w.rd = ard; w.data = adat;
        end else if (win_ld) begin
            e = ld_q.pop_front();
            w.we = (e.rd != 0); w.rd = e.rd; w.data = e.data;
        end
        if (lv && e_lr) ld_q.push_back('{rd: lrd, data: ldat});
        exp_q.push_back(w);
        out_we = w.we;
        out_rd = w.rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        alu_valid = 1'b0; ld_valid = 1'b0;
        #1;
        chk("rst_ld_count", 64'(ld_count), 64'd0);
        chk("rst_busy_mask", 64'(busy_mask), 64'd0);
        chk("rst_we", 64'(rf_write_enable), 64'd0);
        chk("rst_a3", 64'(rf_a3), 64'd0);
        chk("rst_data", 64'(rf_write_data), 64'd0);
        ld_q.delete();
        out_we = 1'b0;
        out_rd = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: one expected write-port outcome per clock edge.
    initial begin : monitor
        wr_t               w;
        logic [REG_AW-1:0] last_rd;
        logic [XLEN-1:0]   last_data;
        last_rd = '0;
        last_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                last_rd = '0;
                last_data = '0;
                exp_q.delete();
            end else if (exp_q.size() == 0) begin
                chk("idle_we", 64'(rf_write_enable), 64'd0);
            end else begin
                w = exp_q.pop_front();
                chk("wr_enable", 64'(rf_write_enable), 64'(w.we));
                if (w.we) begin
                    chk("wr_a3", 64'(rf_a3), 64'(w.rd));
                    chk("wr_data", 64'(rf_write_data), 64'(w.data));
                    last_rd = w.rd;
                    last_data = w.data;
                end else begin
                    chk("hold_a3", 64'(rf_a3), 64'(last_rd));
                    chk("hold_data", 64'(rf_write_data), 64'(last_data));
                end
            end
        end
    end

    initial begin : driver
        #1;
        chk("por_ld_count", 64'(ld_count), 64'd0);
        chk("por_busy_mask", 64'(busy_mask), 64'd0);
        chk("por_we", 64'(rf_write_enable), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single ALU write.
        step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        idle(2);

        // Back-to-back loads retire in order, two edges after enqueue.
        for (int i = 1; i <= 4; i++) step(0, '0, '0, 1, 5'(i), 32'h1000 + 32'(i));
        idle(4);

        // Continuous ALU traffic lets the FIFO fill; full then forces pops.
        for (int i = 0; i < 12; i++) step(1, 5'd9, 32'h9000 + 32'(i), 1, 5'(10 + i), 32'hA000 + 32'(i));
        for (int i = 0; i < 4; i++) step(1, 5'd9, 32'h9100 + 32'(i), 0, '0, '0);
        idle(6);

        // WAW guard against a queued load to r7.
        step(1, 5'd3, 32'h33, 1, 5'd7, 32'h7777);
        for (int i = 0; i < 4; i++) step(1, 5'd7, 32'hA7A7, 0, '0, '0);
        idle(3);

        // Writes to x0 are consumed silently.
        step(1, 5'd0, 32'h1234, 0, '0, '0);
        step(0, '0, '0, 1, 5'd0, 32'h5555);
        idle(3);

        // Reset with three loads queued behind ALU traffic.
        for (int i = 0; i < 3; i++) step(1, 5'd9, 32'h9200 + 32'(i), 1, 5'(20 + i), 32'hB000 + 32'(i));
        do_reset();
        idle(3);

        // Randomized traffic with a narrow rd range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 bit'(($urandom % 4) != 0), 5'($urandom_range(0, 7)), $urandom);
            if (i == 1500) do_reset();
        end
        idle(LD + 4);

        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
